// File: rtl/centroid_pkg.sv
// rtl/centroid_pkg.sv - FSM state and select encodings shared by the centroid divider feeder
package centroid_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        NORM    = 3'd2,
        START   = 3'd3,
        WAIT_LO = 3'd4,
        WAIT_HI = 3'd5,
        OUT     = 3'd6
    } state_e;

    // Which moment is being divided by sum_I in the current pass.
    typedef enum logic {
        SEL_X = 1'b0,
        SEL_Y = 1'b1
    } sel_e;

    // Widest moment accumulator the normaliser helper can inspect.
    localparam int MAX_SUM_W = 64;

    // True when an operand does not fit in the divider's non-negative N-bit word,
    // i.e. any bit at or above position N-1 is set.
    function automatic logic over_width(input logic [MAX_SUM_W-1:0] v, input int n);
        return (v >> (n - 1)) != '0;
    endfunction

endpackage

// File: rtl/centroid_div_feeder.sv
// rtl/centroid_div_feeder.sv - frame moment accumulator that drives a serial divider for the intensity centroid
module centroid_div_feeder
    import centroid_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int X_W   = 12,
    parameter int Y_W   = 12,
    parameter int SUM_W = 48,
    parameter int Q     = 15,
    parameter int N     = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_pix_valid,
    input  logic [PIX_W-1:0] i_pix_data,
    input  logic             i_sof,
    input  logic             i_eol,
    input  logic             i_eof,
    output logic [N-1:0]     o_div_dividend,
    output logic [N-1:0]     o_div_divisor,
    output logic             o_div_start,
    input  logic             i_div_complete,
    input  logic [N-1:0]     i_div_quotient,
    input  logic             i_div_overflow,
    output logic             o_cent_valid,
    output logic [N-1:0]     o_cent_x,
    output logic [N-1:0]     o_cent_y,
    output logic             o_cent_err,
    output logic             o_frame_drop
);

    // Q is a property of the attached divider; the feeder only passes operands through.
    localparam int Q_FRAC = Q;

    // ------------------------------------------------------------------
    // Live accumulation (runs every beat, never stalls)
    // ------------------------------------------------------------------
    logic [X_W-1:0]       x_q, x_cur;
    logic [Y_W-1:0]       y_q, y_cur;
    logic [X_W+PIX_W-1:0] prod_x;
    logic [Y_W+PIX_W-1:0] prod_y;
    logic [SUM_W-1:0]     term_i, term_xi, term_yi;
    logic [SUM_W-1:0]     acc_i_q, acc_xi_q, acc_yi_q;
    logic [SUM_W-1:0]     sum_i, sum_xi, sum_yi;
    logic [SUM_W-1:0]     snap_i_q, snap_xi_q, snap_yi_q;
    logic                 eof_beat, eof_take, eof_drop;
    logic                 frame_drop_q;

    // ------------------------------------------------------------------
    // Division sequencer
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    sel_e             sel_q, sel_d;
    logic [SUM_W-1:0] num_q, num_d;
    logic [SUM_W-1:0] den_q, den_d;
    logic [N-1:0]     res_x_q, res_x_d;
    logic [N-1:0]     res_y_q, res_y_d;
    logic             err_q, err_d;
    logic [N-1:0]     dividend_q, dividend_d;
    logic [N-1:0]     divisor_q, divisor_d;
    logic             start_q, start_d;
    logic             cent_valid_q, cent_valid_d;
    logic [N-1:0]     cent_x_q, cent_x_d;
    logic [N-1:0]     cent_y_q, cent_y_d;
    logic             cent_err_q, cent_err_d;
    logic             need_norm;

    // Coordinates of the current beat and the running sums including it; sof restarts at the origin.
    always_comb begin
        x_cur   = i_sof ? '0 : x_q;
        y_cur   = i_sof ? '0 : y_q;
        prod_x  = {{PIX_W{1'b0}}, x_cur} * {{X_W{1'b0}}, i_pix_data};
        prod_y  = {{PIX_W{1'b0}}, y_cur} * {{Y_W{1'b0}}, i_pix_data};
        term_i  = {{(SUM_W-PIX_W){1'b0}}, i_pix_data};
        term_xi = {{(SUM_W-X_W-PIX_W){1'b0}}, prod_x};
        term_yi = {{(SUM_W-Y_W-PIX_W){1'b0}}, prod_y};
        sum_i   = (i_sof ? '0 : acc_i_q)  + term_i;
        sum_xi  = (i_sof ? '0 : acc_xi_q) + term_xi;
        sum_yi  = (i_sof ? '0 : acc_yi_q) + term_yi;
    end

    assign eof_beat = i_pix_valid && i_eof;
    assign eof_take = eof_beat && (state_q == IDLE);
    assign eof_drop = eof_beat && (state_q != IDLE);

    // Pixel counters and live moment accumulators.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            x_q      <= '0;
            y_q      <= '0;
            acc_i_q  <= '0;
            acc_xi_q <= '0;
            acc_yi_q <= '0;
        end else if (i_pix_valid) begin
            x_q      <= i_eol ? '0 : x_cur + X_W'(1);
            y_q      <= i_eol ? y_cur + Y_W'(1) : y_cur;
            acc_i_q  <= sum_i;
            acc_xi_q <= sum_xi;
            acc_yi_q <= sum_yi;
        end
    end

    // Snapshot of a finished frame for the sequencer; a frame ending while it is busy is discarded.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            snap_i_q     <= '0;
            snap_xi_q    <= '0;
            snap_yi_q    <= '0;
            frame_drop_q <= 1'b0;
        end else begin
            frame_drop_q <= eof_drop;
            if (eof_take) begin
                snap_i_q  <= sum_i;
                snap_xi_q <= sum_xi;
                snap_yi_q <= sum_yi;
            end
        end
    end

    assign need_norm = over_width(MAX_SUM_W'(num_q), N) || over_width(MAX_SUM_W'(den_q), N);

    // Sequencer next state: load operands, normalise into the divider word, run X then Y divisions.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        num_d        = num_q;
        den_d        = den_q;
        res_x_d      = res_x_q;
        res_y_d      = res_y_q;
        err_d        = err_q;
        dividend_d   = dividend_q;
        divisor_d    = divisor_q;
        start_d      = 1'b0;
        cent_valid_d = 1'b0;
        cent_x_d     = cent_x_q;
        cent_y_d     = cent_y_q;
        cent_err_d   = cent_err_q;
        case (state_q)
            IDLE: begin
                if (eof_take) begin
                    state_d = LOAD;
                    sel_d   = SEL_X;
                    err_d   = 1'b0;
                end
            end
            LOAD: begin
                num_d = (sel_q == SEL_Y) ? snap_yi_q : snap_xi_q;
                den_d = snap_i_q;
                if (snap_i_q == '0) begin
                    // Dark frame: no division is meaningful, report an error centroid at origin.
                    res_x_d = '0;
                    res_y_d = '0;
                    err_d   = 1'b1;
                    state_d = OUT;
                end else begin
                    state_d = NORM;
                end
            end
            NORM: begin
                // Shifting both operands together keeps the ratio while fitting the signed divider word.
                if (need_norm) begin
                    num_d = num_q >> 1;
                    den_d = den_q >> 1;
                end else begin
                    state_d = START;
                end
            end
            START: begin
                // Only launch into an idle divider; otherwise hold here with start low.
                if (i_div_complete) begin
                    dividend_d = num_q[N-1:0];
                    divisor_d  = den_q[N-1:0];
                    start_d    = 1'b1;
                    state_d    = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!i_div_complete) begin
                    state_d = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (i_div_complete) begin
                    err_d = err_q | i_div_overflow;
                    if (sel_q == SEL_X) begin
                        res_x_d = i_div_quotient;
                        sel_d   = SEL_Y;
                        state_d = LOAD;
                    end else begin
                        res_y_d = i_div_quotient;
                        state_d = OUT;
                    end
                end
            end
            OUT: begin
                cent_valid_d = 1'b1;
                cent_x_d     = res_x_q;
                cent_y_d     = res_y_q;
                cent_err_d   = err_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state and registered divider/centroid outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            sel_q        <= SEL_X;
            num_q        <= '0;
            den_q        <= '0;
            res_x_q      <= '0;
            res_y_q      <= '0;
            err_q        <= 1'b0;
            dividend_q   <= '0;
            divisor_q    <= '0;
            start_q      <= 1'b0;
            cent_valid_q <= 1'b0;
            cent_x_q     <= '0;
            cent_y_q     <= '0;
            cent_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            num_q        <= num_d;
            den_q        <= den_d;
            res_x_q      <= res_x_d;
            res_y_q      <= res_y_d;
            err_q        <= err_d;
            dividend_q   <= dividend_d;
            divisor_q    <= divisor_d;
            start_q      <= start_d;
            cent_valid_q <= cent_valid_d;
            cent_x_q     <= cent_x_d;
            cent_y_q     <= cent_y_d;
            cent_err_q   <= cent_err_d;
        end
    end

    assign o_div_dividend = dividend_q;
    assign o_div_divisor  = divisor_q;
    assign o_div_start    = start_q;
    assign o_cent_valid   = cent_valid_q;
    assign o_cent_x       = cent_x_q;
    assign o_cent_y       = cent_y_q;
    assign o_cent_err     = cent_err_q;
    assign o_frame_drop   = frame_drop_q;

    if (Q_FRAC < 0) begin : g_bad_q
        $error("Q must be non-negative");
    end

endmodule

// File: tb/tb_centroid_div_feeder.sv
// tb/tb_centroid_div_feeder.sv - directed bench for centroid_div_feeder with behavioural dividers
module tb_centroid_div_feeder;

    localparam int DIV_LAT = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       pv = 1'b0;
    logic [7:0] pd = '0;
    logic       sof = 1'b0, eol = 1'b0, eof = 1'b0;
    logic       busy_force = 1'b0;
    logic       ovf_y = 1'b0;

    int total = 0;
    int bad = 0;

    // DUT A: default N=32, Q=15
    logic [31:0] a_dvd, a_dvs, a_quo, a_x, a_y;
    logic a_start, a_cmp_m, a_cmp, a_ovf, a_valid, a_err, a_drop;
    int a_cnt, a_idx;
    int a_starts = 0, a_valids = 0, a_drops = 0;

    // DUT B: N=16, Q=8
    logic [15:0] b_dvd, b_dvs, b_quo, b_x, b_y;
    logic b_start, b_cmp_m, b_cmp, b_ovf, b_valid, b_err, b_drop;
    int b_cnt, b_idx;
    int b_starts = 0, b_valids = 0;
    logic [15:0] b_dvd_x = '0, b_dvs_x = '0;

    centroid_div_feeder dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_pix_valid(pv), .i_pix_data(pd),
        .i_sof(sof), .i_eol(eol), .i_eof(eof),
        .o_div_dividend(a_dvd), .o_div_divisor(a_dvs), .o_div_start(a_start),
        .i_div_complete(a_cmp), .i_div_quotient(a_quo), .i_div_overflow(a_ovf),
        .o_cent_valid(a_valid), .o_cent_x(a_x), .o_cent_y(a_y), .o_cent_err(a_err),
        .o_frame_drop(a_drop)
    );

    centroid_div_feeder #(.N(16), .Q(8)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_pix_valid(pv), .i_pix_data(pd),
        .i_sof(sof), .i_eol(eol), .i_eof(eof),
        .o_div_dividend(b_dvd), .o_div_divisor(b_dvs), .o_div_start(b_start),
        .i_div_complete(b_cmp), .i_div_quotient(b_quo), .i_div_overflow(b_ovf),
        .o_cent_valid(b_valid), .o_cent_x(b_x), .o_cent_y(b_y), .o_cent_err(b_err),
        .o_frame_drop(b_drop)
    );

    function automatic longint unsigned div_q(input longint unsigned dvd, input longint unsigned dvs, input int q);
        if (dvs == 0) return 64'hFFFF_FFFF_FFFF_FFFF;
        return (dvd << q) / dvs;
    endfunction

    assign a_cmp = a_cmp_m & ~busy_force;
    assign b_cmp = b_cmp_m & ~busy_force;

    // divider model A: accepts start while idle, busy DIV_LAT cycles, odd divisions may be forced to overflow
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_cmp_m <= 1'b1; a_cnt <= 0; a_quo <= '0; a_ovf <= 1'b0; a_idx <= 0;
        end else if (a_cnt != 0) begin
            a_cnt <= a_cnt - 1;
            if (a_cnt == 1) a_cmp_m <= 1'b1;
        end else if (a_start && a_cmp) begin
            a_cmp_m <= 1'b0; a_cnt <= DIV_LAT; a_idx <= a_idx + 1;
            a_quo <= 32'(div_q(64'(a_dvd), 64'(a_dvs), 15));
            a_ovf <= (div_q(64'(a_dvd), 64'(a_dvs), 15) >= 64'h8000_0000) || (ovf_y && a_idx[0]);
        end
    end

    // divider model B
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_cmp_m <= 1'b1; b_cnt <= 0; b_quo <= '0; b_ovf <= 1'b0; b_idx <= 0;
        end else if (b_cnt != 0) begin
            b_cnt <= b_cnt - 1;
            if (b_cnt == 1) b_cmp_m <= 1'b1;
        end else if (b_start && b_cmp) begin
            b_cmp_m <= 1'b0; b_cnt <= DIV_LAT; b_idx <= b_idx + 1;
            b_quo <= 16'(div_q(64'(b_dvd), 64'(b_dvs), 8));
            b_ovf <= (div_q(64'(b_dvd), 64'(b_dvs), 8) >= 64'h8000) || (ovf_y && b_idx[0]);
            if (!b_idx[0]) begin
                b_dvd_x <= b_dvd;
                b_dvs_x <= b_dvs;
            end
        end
    end

    // event counters
    always @(posedge clk) begin
        if (a_start) a_starts <= a_starts + 1;
        if (b_start) b_starts <= b_starts + 1;
        if (a_valid) a_valids <= a_valids + 1;
        if (b_valid) b_valids <= b_valids + 1;
        if (a_drop)  a_drops  <= a_drops + 1;
    end

    task automatic beat(input logic [7:0] d, input logic s, input logic l, input logic f);
        pv = 1'b1; pd = d; sof = s; eol = l; eof = f;
        @(posedge clk); #1;
        pv = 1'b0; pd = '0; sof = 1'b0; eol = 1'b0; eof = 1'b0;
    endtask

    task automatic wait_done(input int a0, input int b0, input string nm);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (a_valids > a0 && b_valids > b0) return;
        end
        total++; bad++;
        $display("FAIL %s_timeout: centroid valid not seen within 400 cycles", nm);
    endtask

    task automatic frame_peak();
        beat(8'd0, 1'b1, 1'b0, 1'b0);
        beat(8'd0, 1'b0, 1'b0, 1'b0);
        beat(8'd10, 1'b0, 1'b0, 1'b0);
        beat(8'd0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic frame_2x2();
        beat(8'd1, 1'b1, 1'b0, 1'b0);
        beat(8'd2, 1'b0, 1'b1, 1'b0);
        beat(8'd3, 1'b0, 1'b0, 1'b0);
        beat(8'd4, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", a_valid); end
        total++; if (a_x !== 32'h0) begin bad++; $display("FAIL rst_x: got %h want 0", a_x); end
        total++; if (a_y !== 32'h0) begin bad++; $display("FAIL rst_y: got %h want 0", a_y); end
        total++; if (a_err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", a_err); end
        total++; if (a_drop !== 1'b0) begin bad++; $display("FAIL rst_drop: got %b want 0", a_drop); end
        total++; if (a_start !== 1'b0) begin bad++; $display("FAIL rst_start: got %b want 0", a_start); end
        total++; if (a_dvd !== 32'h0) begin bad++; $display("FAIL rst_dividend: got %h want 0", a_dvd); end
        total++; if (a_dvs !== 32'h0) begin bad++; $display("FAIL rst_divisor: got %h want 0", a_dvs); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_peak();
        int a0 = a_valids, b0 = b_valids;
        frame_peak();
        wait_done(a0, b0, "peak");
        total++; if (a_x !== 32'h0001_0000) begin bad++; $display("FAIL peak_x: got %h want 00010000", a_x); end
        total++; if (a_y !== 32'h0) begin bad++; $display("FAIL peak_y: got %h want 0", a_y); end
        total++; if (a_err !== 1'b0) begin bad++; $display("FAIL peak_err: got %b want 0", a_err); end
        total++; if (b_x !== 16'h0200) begin bad++; $display("FAIL peak_x16: got %h want 0200", b_x); end
        total++; if (b_err !== 1'b0) begin bad++; $display("FAIL peak_err16: got %b want 0", b_err); end
    endtask

    task automatic test_zero_frame();
        int a0 = a_valids, b0 = b_valids, s0 = a_starts, t0 = b_starts;
        beat(8'd0, 1'b1, 1'b0, 1'b0);
        beat(8'd0, 1'b0, 1'b0, 1'b0);
        beat(8'd0, 1'b0, 1'b1, 1'b0);
        beat(8'd0, 1'b0, 1'b0, 1'b0);
        beat(8'd0, 1'b0, 1'b0, 1'b0);
        beat(8'd0, 1'b0, 1'b1, 1'b1);
        wait_done(a0, b0, "zero");
        total++; if (a_err !== 1'b1) begin bad++; $display("FAIL zero_err: got %b want 1", a_err); end
        total++; if (a_x !== 32'h0) begin bad++; $display("FAIL zero_x: got %h want 0", a_x); end
        total++; if (a_y !== 32'h0) begin bad++; $display("FAIL zero_y: got %h want 0", a_y); end
        total++; if (a_starts !== s0) begin bad++; $display("FAIL zero_nostart: got %0d starts want %0d", a_starts, s0); end
        total++; if (b_starts !== t0) begin bad++; $display("FAIL zero_nostart16: got %0d starts want %0d", b_starts, t0); end
    endtask

    task automatic test_norm();
        int a0 = a_valids, b0 = b_valids;
        for (int i = 0; i < 64; i++) beat(8'd255, i == 0, i == 63, i == 63);
        wait_done(a0, b0, "norm");
        total++; if (b_dvd_x !== 16'd32130) begin bad++; $display("FAIL norm_dividend: got %0d want 32130", b_dvd_x); end
        total++; if (b_dvs_x !== 16'd1020) begin bad++; $display("FAIL norm_divisor: got %0d want 1020", b_dvs_x); end
        total++; if (b_x !== 16'h1F80) begin bad++; $display("FAIL norm_x16: got %h want 1f80", b_x); end
        total++; if (b_y !== 16'h0) begin bad++; $display("FAIL norm_y16: got %h want 0", b_y); end
        total++; if (a_x !== 32'h000F_C000) begin bad++; $display("FAIL norm_x32: got %h want 000fc000", a_x); end
    endtask

    task automatic test_multirow();
        int a0 = a_valids, b0 = b_valids;
        frame_2x2();
        wait_done(a0, b0, "multirow");
        total++; if (a_x !== 32'd19660) begin bad++; $display("FAIL multi_x: got %0d want 19660", a_x); end
        total++; if (a_y !== 32'd22937) begin bad++; $display("FAIL multi_y: got %0d want 22937", a_y); end
        total++; if (a_err !== 1'b0) begin bad++; $display("FAIL multi_err: got %b want 0", a_err); end
        total++; if (b_y !== 16'd179) begin bad++; $display("FAIL multi_y16: got %0d want 179", b_y); end
    endtask

    task automatic test_ovf_y();
        int a0 = a_valids, b0 = b_valids;
        ovf_y = 1'b1;
        frame_2x2();
        wait_done(a0, b0, "ovf");
        ovf_y = 1'b0;
        total++; if (a_err !== 1'b1) begin bad++; $display("FAIL ovf_err: got %b want 1", a_err); end
        total++; if (a_x !== 32'd19660) begin bad++; $display("FAIL ovf_x: got %0d want 19660", a_x); end
        total++; if (b_err !== 1'b1) begin bad++; $display("FAIL ovf_err16: got %b want 1", b_err); end
    endtask

    task automatic test_start_hold();
        int a0 = a_valids, b0 = b_valids, s0 = a_starts;
        busy_force = 1'b1;
        beat(8'd5, 1'b1, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        total++; if (a_starts !== s0) begin bad++; $display("FAIL hold_nostart: got %0d starts want %0d", a_starts, s0); end
        total++; if (a_valids !== a0) begin bad++; $display("FAIL hold_novalid: got %0d valids want %0d", a_valids, a0); end
        busy_force = 1'b0;
        wait_done(a0, b0, "hold");
        total++; if (a_x !== 32'h0) begin bad++; $display("FAIL hold_x: got %h want 0", a_x); end
        total++; if (a_y !== 32'h0) begin bad++; $display("FAIL hold_y: got %h want 0", a_y); end
        total++; if (a_starts !== s0 + 2) begin bad++; $display("FAIL hold_starts: got %0d want %0d", a_starts, s0 + 2); end
    endtask

    task automatic test_drop();
        int a0 = a_valids, b0 = b_valids, d0 = a_drops;
        frame_peak();
        beat(8'd0, 1'b1, 1'b1, 1'b0);
        beat(8'd9, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        total++; if (a_drops !== d0 + 1) begin bad++; $display("FAIL drop_pulse: got %0d drops want %0d", a_drops, d0 + 1); end
        wait_done(a0, b0, "drop");
        repeat (60) @(negedge clk);
        total++; if (a_valids !== a0 + 1) begin bad++; $display("FAIL drop_once: got %0d valids want %0d", a_valids, a0 + 1); end
        total++; if (a_x !== 32'h0001_0000) begin bad++; $display("FAIL drop_x: got %h want 00010000", a_x); end
        total++; if (a_y !== 32'h0) begin bad++; $display("FAIL drop_y: got %h want 0", a_y); end
    endtask

    task automatic test_reset_mid();
        int a0, b0, s0 = a_starts;
        frame_peak();
        for (int i = 0; i < 200 && a_starts == s0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (a_x !== 32'h0) begin bad++; $display("FAIL mid_rst_x: got %h want 0", a_x); end
        total++; if (a_dvd !== 32'h0) begin bad++; $display("FAIL mid_rst_dividend: got %h want 0", a_dvd); end
        total++; if (a_dvs !== 32'h0) begin bad++; $display("FAIL mid_rst_divisor: got %h want 0", a_dvs); end
        total++; if (a_valid !== 1'b0 || a_start !== 1'b0 || a_err !== 1'b0) begin
            bad++; $display("FAIL mid_rst_flags: got valid=%b start=%b err=%b want 0", a_valid, a_start, a_err);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        a0 = a_valids; b0 = b_valids;
        frame_2x2();
        wait_done(a0, b0, "mid");
        total++; if (a_x !== 32'd19660) begin bad++; $display("FAIL mid_after_x: got %0d want 19660", a_x); end
        total++; if (a_y !== 32'd22937) begin bad++; $display("FAIL mid_after_y: got %0d want 22937", a_y); end
    endtask

    initial begin
        test_reset();
        test_peak();
        test_zero_frame();
        test_norm();
        test_multirow();
        test_ovf_y();
        test_start_hold();
        test_drop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
